// File: rtl/hdmi_line_dma.sv
// hdmi_line_dma: line-fetch DMA engine for the HDMI output path (system clock).
// Each line request issues cfg_bn_cnt normal read bursts plus one last burst and
// writes the returned 16-bit words into a ring of 2^NBUF_LOG2 line buffers.
// Optional feature macro: HDMI_LINE_DMA_VREPEAT_EN (fetch only every
// cfg_vrep+1 requests, so one fetched line is repeated on screen).
`timescale 1ns/1ps

module hdmi_line_dma #(
    parameter int ADDR_W    = 23,
    parameter int LEN_W     = 7,
    parameter int BUF_AW    = 9,
    parameter int NBUF_LOG2 = 1,
    parameter int CNT_W     = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_run,
    input  logic [ADDR_W-1:0]           cfg_base,
    input  logic [CNT_W-1:0]            cfg_bn_cnt,
    input  logic [LEN_W-1:0]            cfg_bn_len,
    input  logic [LEN_W-1:0]            cfg_bl_len,
    input  logic [LEN_W:0]              cfg_bl_inc,
`ifdef HDMI_LINE_DMA_VREPEAT_EN
    input  logic [1:0]                  cfg_vrep,
`endif
    input  logic                        lreq_stb,
    input  logic                        lreq_first,
    output logic [ADDR_W-1:0]           mi_addr,
    output logic [LEN_W-1:0]            mi_len,
    output logic                        mi_rw,
    output logic                        mi_valid,
    input  logic                        mi_ready,
    input  logic [15:0]                 mi_rdata,
    input  logic                        mi_rstb,
    input  logic                        mi_rlast,
    output logic [NBUF_LOG2+BUF_AW-1:0] buf_waddr,
    output logic [15:0]                 buf_wdata,
    output logic                        buf_wren,
    output logic                        stat_busy,
    output logic                        stat_overrun,
    output logic                        stat_trunc,
    input  logic                        stat_clr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [BUF_AW-1:0] WORD_MAX = '1;

    logic [1:0]           state;
    logic [ADDR_W-1:0]    addr;
    logic [CNT_W-1:0]     bcnt;
    logic [CNT_W:0]       outst;
    logic [NBUF_LOG2-1:0] bidx;
    logic [BUF_AW-1:0]    word;
    logic                 word_full;
    logic                 pend_vld;
    logic                 pend_first;
    logic                 hs;
    logic                 rd_ok;
    logic                 rdone;
    logic                 wr;
    logic                 drop;
    logic                 req_hit;
    logic                 start;
    logic                 start_first;

    // Next burst address: increment fields are length-1 encoded, wrap at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                    input logic [LEN_W:0]    inc);
        return a + ADDR_W'(inc) + ADDR_W'(1);
    endfunction

    // Word index saturates on the last buffer entry.
    function automatic logic [BUF_AW-1:0] word_sat_inc(input logic [BUF_AW-1:0] w);
        return (w == WORD_MAX) ? w : w + 1'b1;
    endfunction

    assign hs    = mi_valid & mi_ready;
    assign rd_ok = mi_rstb & (outst != '0);
    assign rdone = rd_ok & mi_rlast;
    assign wr    = rd_ok & ~word_full;
    assign drop  = rd_ok & word_full;

    assign mi_rw     = 1'b1;
    assign mi_valid  = (state == REQ);
    assign mi_addr   = addr;
    assign mi_len    = (state != REQ) ? '0 : ((bcnt == '0) ? cfg_bl_len : cfg_bn_len);
    assign buf_wren  = wr;
    assign buf_waddr = {bidx, word};
    assign buf_wdata = mi_rdata;
    assign stat_busy = (state != IDLE);

`ifdef HDMI_LINE_DMA_VREPEAT_EN
    logic [1:0] phase;
    logic [1:0] phase_nxt;

    // Request phase: a first-line request restarts the repeat cycle.
    always_comb begin
        phase_nxt = (lreq_first || phase == cfg_vrep) ? 2'd0 : phase + 2'd1;
    end

    assign req_hit = lreq_stb & (phase_nxt == 2'd0);

    // Track the repeat phase on every request strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= 2'd0;
        else if (lreq_stb)
            phase <= phase_nxt;
    end
`else
    assign req_hit = lreq_stb;
`endif

    // A held pending request counts as a strobe once the engine is idle.
    assign start       = (state == IDLE) & cfg_run & (req_hit | pend_vld);
    assign start_first = req_hit ? lreq_first : pend_first;

    // Burst sequencer: line start, request handshakes, then wait for data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            bcnt  <= '0;
            bidx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= REQ;
                        bcnt  <= cfg_bn_cnt;
                        if (start_first) begin
                            addr <= cfg_base;
                            bidx <= '0;
                        end else begin
                            bidx <= bidx + 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (hs) begin
                        addr <= addr_step(addr, (bcnt == '0) ? cfg_bl_inc : {1'b0, cfg_bn_len});
                        bcnt <= bcnt - 1'b1;
                        // Dropping cfg_run cancels the bursts not yet presented.
                        if (bcnt == '0 || !cfg_run)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outst == '0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outstanding bursts: accepted requests not yet finished by rlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outst <= '0;
        else if (hs && !rdone)
            outst <= outst + 1'b1;
        else if (rdone && !hs)
            outst <= outst - 1'b1;
    end

    // Buffer word index; once the last entry is written the line is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            word_full <= 1'b0;
        end else if (start) begin
            word      <= '0;
            word_full <= 1'b0;
        end else if (wr) begin
            if (word == WORD_MAX)
                word_full <= 1'b1;
            word <= word_sat_inc(word);
        end
    end

    // One-deep pending slot: the newest request taken while busy wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld   <= 1'b0;
            pend_first <= 1'b0;
        end else if (!cfg_run) begin
            pend_vld <= 1'b0;
        end else if (req_hit && state != IDLE) begin
            pend_vld   <= 1'b1;
            pend_first <= lreq_first;
        end else if (start) begin
            pend_vld <= 1'b0;
        end
    end

    // Sticky status flags; a clear wins over a simultaneous set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_overrun <= 1'b0;
            stat_trunc   <= 1'b0;
        end else if (stat_clr) begin
            stat_overrun <= 1'b0;
            stat_trunc   <= 1'b0;
        end else begin
            if (req_hit && state != IDLE)
                stat_overrun <= 1'b1;
            if (drop)
                stat_trunc <= 1'b1;
        end
    end

endmodule
